// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and output payload type for the 16-bit fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00001;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = {OPC_NOP, (XLEN - OPC_W)'(0)};
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [XLEN-1:0] PC_STEP       = 16'h0002;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_two;
  } fetch_out_t;

  // Instruction addresses are halfword aligned; bit 0 set is an illegal target.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  input  logic        sign,
  output logic [15:0] s,
  output logic        co,
  output logic        ovf
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = ci;
    // Each group derives its internal carries from its own carry-in only.
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
    end
  end

  assign s   = p ^ c[15:0];
  assign co  = c[16];
  assign ovf = sign ? (c[16] ^ c[15]) : c[16];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch FSM: tracks outstanding requests across redirects and selects the imem request/address.
module fetch_ctrl
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect,
  input  logic         redirect_misaligned,
  input  logic         stall,
  input  logic         instr_valid,
  input  logic         imem_ready,
  input  logic         rdata_halt,
  input  logic [15:0]  pc_reg,
  output logic         imem_req_c,
  output logic [15:0]  imem_addr_c,
  output logic         accept_c,
  output fetch_state_e state
);

  fetch_state_e state_q, state_d;
  logic [15:0]  drain_addr_q, drain_addr_d;
  logic         req_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    req_raw      = 1'b0;
    imem_addr_c  = pc_reg;

    unique case (state_q)
      ST_FETCH: req_raw = !(instr_valid && stall);
      ST_DRAIN: begin
        req_raw     = 1'b1;
        imem_addr_c = drain_addr_q;
      end
      default: ;
    endcase

    imem_req_c = req_raw && rst_n;
    accept_c   = (state_q == ST_FETCH) && imem_req_c && imem_ready && !redirect;

    // Redirect wins over stall and ready; an unanswered request must be drained first.
    if (redirect) begin
      if (redirect_misaligned) begin
        state_d = ST_HALTED;
      end else if ((state_q == ST_FETCH) && imem_req_c && !imem_ready) begin
        state_d      = ST_DRAIN;
        drain_addr_d = pc_reg;
      end else if ((state_q == ST_DRAIN) && !imem_ready) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_FETCH:  if (accept_c && rdata_halt) state_d = ST_HALTED;
        ST_DRAIN:  if (imem_ready) state_d = ST_FETCH;
        ST_HALTED: ;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural PC, imem interface and the registered decode-side slot.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF,
  parameter logic [4:0]  HALT_OPCODE = OPC_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus_two,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  fetch_out_t   out_q, out_d;
  logic [15:0]  pc_reg_q, pc_reg_d;
  logic         instr_valid_q, instr_valid_d;
  logic         err_q, err_d;
  logic [15:0]  pc_inc;
  logic         accept_c;
  logic         rdata_halt;
  logic         redirect_misaligned;
  logic         slot_free;
  fetch_state_e state;
  logic         inc_co_unused;
  logic         inc_ovf_unused;

  assign rdata_halt          = (imem_rdata[15:11] == HALT_OPCODE);
  assign redirect_misaligned = is_misaligned(next_pc);
  assign slot_free           = !instr_valid_q || !stall;

  cla_16bit u_pc_inc (
    .a    (pc_reg_q),
    .b    (PC_STEP),
    .ci   (1'b0),
    .sign (1'b0),
    .s    (pc_inc),
    .co   (inc_co_unused),
    .ovf  (inc_ovf_unused)
  );

  fetch_ctrl u_ctrl (
    .clk                 (clk),
    .rst_n               (rst_n),
    .redirect            (redirect),
    .redirect_misaligned (redirect_misaligned),
    .stall               (stall),
    .instr_valid         (instr_valid_q),
    .imem_ready          (imem_ready),
    .rdata_halt          (rdata_halt),
    .pc_reg              (pc_reg_q),
    .imem_req_c          (imem_req),
    .imem_addr_c         (imem_addr),
    .accept_c            (accept_c),
    .state               (state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '{instr: NOP_INSTR, pc: '0, pc_plus_two: '0};
      pc_reg_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      out_q         <= out_d;
      pc_reg_q      <= pc_reg_d;
      instr_valid_q <= instr_valid_d;
      err_q         <= err_d;
    end
  end

  // Output slot: flush on redirect, load on accepted response, bubble when free and idle.
  always_comb begin
    out_d         = out_q;
    pc_reg_d      = pc_reg_q;
    instr_valid_d = instr_valid_q;
    err_d         = err_q;

    if (redirect) begin
      pc_reg_d      = next_pc;
      instr_valid_d = 1'b0;
      out_d.instr   = NOP_INSTR;
      if (redirect_misaligned) err_d = 1'b1;
    end else if (accept_c) begin
      out_d.instr       = imem_rdata;
      out_d.pc          = pc_reg_q;
      out_d.pc_plus_two = pc_inc;
      instr_valid_d     = 1'b1;
      pc_reg_d          = pc_inc;
    end else if (slot_free) begin
      instr_valid_d = 1'b0;
      out_d.instr   = NOP_INSTR;
    end
  end

  assign instr       = out_q.instr;
  assign pc          = out_q.pc;
  assign pc_plus_two = out_q.pc_plus_two;
  assign instr_valid = instr_valid_q;
  assign halted      = (state == ST_HALTED);
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected slot contents are queued as responses are driven.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] next_pc = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] pc_plus_two;
  logic        instr_valid;
  logic        halted;
  logic        err;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcp2;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pc_plus_two (pc_plus_two),
    .instr_valid (instr_valid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [15:0] rd, input logic rdr,
                       input logic [15:0] npc, input logic stl);
    imem_ready = rdy;
    imem_rdata = rd;
    redirect   = rdr;
    next_pc    = npc;
    stall      = stl;
    #1;
  endtask

  task automatic push(input logic [15:0] ins, input logic [15:0] addr);
    exp_t e;
    e.instr = ins;
    e.pc    = addr;
    e.pcp2  = addr + 16'd2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({imem_req, instr, pc, pc_plus_two, instr_valid, halted, err} !== {1'b0, NOP, 16'h0, 16'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_state got req=%b instr=%h pc=%h pc2=%h v=%b h=%b e=%b want 0 0800 0000 0000 0 0 0",
               imem_req, instr, pc, pc_plus_two, instr_valid, halted, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL reset_first_req got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h4000 + 16'(k), 1'b0, 16'h0, 1'b0);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(2 * k)) begin
        bad++;
        $display("FAIL zw_req%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, 16'(2 * k));
      end
      push(16'h4000 + 16'(k), 16'(2 * k));
      tick();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL zw_out%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
          bad++;
          $display("FAIL zw_out%0d got %h/%h/%h v=%b want %h/%h/%h v=1", k, instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
        end
      end
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      bad++;
      $display("FAIL zw_bubble got v=%b instr=%h want 0 0800", instr_valid, instr);
    end
  endtask

  task automatic test_latency_redirect();
    exp_t e;
    // Redirect to 0002 while the request at 0006 is unanswered: it must be drained.
    drive(1'b0, 16'h0, 1'b1, 16'h0002, 1'b0);
    tick();
    drive(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0006 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_hold got req=%b addr=%h v=%b want 1 0006 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      bad++;
      $display("FAIL drain_discard got v=%b instr=%h want 0 0800", instr_valid, instr);
    end
    // Three-cycle latency at 0002 with redirect to 0040 in the first wait cycle.
    drive(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL lat_wait1 got req=%b addr=%h want 1 0002", imem_req, imem_addr);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_wait2 got req=%b addr=%h v=%b want 1 0002 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL lat_wait3 got req=%b addr=%h want 1 0002", imem_req, imem_addr);
    end
    tick();
    drive(1'b1, 16'h5040, 1'b0, 16'h0, 1'b0);
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL lat_resume got v=%b req=%b addr=%h want 0 1 0040", instr_valid, imem_req, imem_addr);
    end
    push(16'h5040, 16'h0040);
    tick();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL lat_out scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
        bad++;
        $display("FAIL lat_out got %h/%h/%h v=%b want %h/%h/%h v=1", instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    drive(1'b1, 16'hBEEF, 1'b1, 16'h0006, 1'b0);
    tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      bad++;
      $display("FAIL st_flush got v=%b instr=%h want 0 0800", instr_valid, instr);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h6006 + 16'(2 * k), 1'b0, 16'h0, 1'b0);
      push(16'h6006 + 16'(2 * k), 16'h0006 + 16'(2 * k));
      tick();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL st_out%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
          bad++;
          $display("FAIL st_out%0d got %h/%h/%h v=%b want %h/%h/%h v=1", k, instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
        end
      end
      if (k == 0) begin
        for (int c = 0; c < 4; c++) begin
          drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
          tick();
          total++;
          if ({imem_req, instr, pc, pc_plus_two, instr_valid} !== {1'b0, 16'h6006, 16'h0006, 16'h0008, 1'b1}) begin
            bad++;
            $display("FAIL st_hold%0d got req=%b %h/%h/%h v=%b want 0 6006/0006/0008 v=1", c, imem_req, instr, pc, pc_plus_two, instr_valid);
          end
        end
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    drive(1'b1, 16'hBEEF, 1'b1, 16'h0010, 1'b0);
    tick();
    drive(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0);
    push(16'h0000, 16'h0010);
    tick();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL halt_out scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
        bad++;
        $display("FAIL halt_out got %h/%h/%h v=%b want %h/%h/%h v=1", instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
      end
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_stop got halted=%b req=%b want 1 0", halted, imem_req);
    end
    tick();
    total++;
    if ({halted, imem_req, instr_valid, instr} !== {1'b1, 1'b0, 1'b0, NOP}) begin
      bad++;
      $display("FAIL halt_idle got h=%b req=%b v=%b instr=%h want 1 0 0 0800", halted, imem_req, instr_valid, instr);
    end
    drive(1'b0, 16'h0, 1'b1, 16'h0020, 1'b0);
    tick();
    drive(1'b1, 16'h7020, 1'b0, 16'h0, 1'b0);
    total++;
    if ({halted, imem_req, imem_addr, instr_valid} !== {1'b0, 1'b1, 16'h0020, 1'b0}) begin
      bad++;
      $display("FAIL halt_resume got h=%b req=%b addr=%h v=%b want 0 1 0020 0", halted, imem_req, imem_addr, instr_valid);
    end
    push(16'h7020, 16'h0020);
    tick();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL halt_resume_out scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
        bad++;
        $display("FAIL halt_resume_out got %h/%h/%h v=%b want %h/%h/%h v=1", instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
      end
    end
  endtask

  task automatic test_misaligned();
    drive(1'b0, 16'h0, 1'b1, 16'h0031, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      total++;
      if ({err, halted, imem_req, instr_valid} !== 4'b1100) begin
        bad++;
        $display("FAIL mis_err%0d got e=%b h=%b req=%b v=%b want 1 1 0 0", c, err, halted, imem_req, instr_valid);
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++;
    if ({err, halted, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 16'h0040}) begin
      bad++;
      $display("FAIL mis_sticky got e=%b h=%b req=%b addr=%h want 1 0 1 0040", err, halted, imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({err, halted, imem_req} !== 3'b000) begin
      bad++;
      $display("FAIL mis_rst_clear got e=%b h=%b req=%b want 0 0 0", err, halted, imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    drive(1'b1, 16'hBEEF, 1'b1, 16'hFFFE, 1'b0);
    tick();
    drive(1'b1, 16'h4FFE, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_addr !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_addr got %h want fffe", imem_addr);
    end
    push(16'h4FFE, 16'hFFFE);
    tick();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL wrap_out scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
        bad++;
        $display("FAIL wrap_out got %h/%h/%h v=%b want %h/%h/%h v=1", instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
      end
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_next got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, instr, pc, pc_plus_two, instr_valid} !== {1'b0, NOP, 16'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL midrst got req=%b %h/%h/%h v=%b want 0 0800/0000/0000 v=0", imem_req, instr, pc, pc_plus_two, instr_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h4100, 1'b0, 16'h0, 1'b0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_restart got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    push(16'h4100, 16'h0000);
    tick();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL restart_out scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({instr, pc, pc_plus_two, instr_valid} !== {e.instr, e.pc, e.pcp2, 1'b1}) begin
        bad++;
        $display("FAIL restart_out got %h/%h/%h v=%b want %h/%h/%h v=1", instr, pc, pc_plus_two, instr_valid, e.instr, e.pc, e.pcp2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency_redirect();
    test_stall();
    test_halt();
    test_misaligned();
    test_wrap_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
